// File: rtl/contador_bits_param_if.sv
// Request/result bundle for the multi-mode bit counter.
// The requester drives start/mode/a; the counter drives the result and status.
interface contador_bits_param_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) ();
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [CNT_W-1:0] resultado;
  logic             pronto;
  logic             ocupado;
  logic [1:0]       est;

  modport master (output start, mode, a, input resultado, pronto, ocupado, est);
  modport slave  (input start, mode, a, output resultado, pronto, ocupado, est);
endinterface

// File: rtl/contador_bits_param.sv
// Multi-mode bit counter: ones, zeros, leading zeros or trailing zeros,
// one operand bit examined per clock, with a level start/pronto handshake.
//
// state  | meaning
// IDLE   | waiting for start; result of the previous run still visible
// BUSY   | examining one bit per cycle of the latched operand
// DONE   | result valid on pronto; leaves only once start drops
module contador_bits_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic                  clk,
  input logic                  reset,
  contador_bits_param_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic             pronto_q, pronto_d;
  logic             ocupado_q, ocupado_d;
  logic             last_bit;

  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    last_bit = (idx_q == IDX_W'(WIDTH - 1));
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          reg_a_d = bus.a;
          mode_d  = bus.mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        idx_d = idx_q + IDX_W'(1);
        case (mode_q)
          2'b00: begin
            // Stop early once no set bits remain above the examined one.
            reg_a_d = reg_a_q >> 1;
            acc_d   = acc_q + CNT_W'(reg_a_q[0]);
            if (reg_a_d == '0 || last_bit) state_d = S_DONE;
          end
          2'b01: begin
            reg_a_d = reg_a_q >> 1;
            acc_d   = acc_q + CNT_W'(~reg_a_q[0]);
            if (last_bit) state_d = S_DONE;
          end
          2'b10: begin
            if (reg_a_q[WIDTH-1]) begin
              state_d = S_DONE;
            end else begin
              acc_d   = acc_q + CNT_W'(1);
              reg_a_d = reg_a_q << 1;
              if (last_bit) state_d = S_DONE;
            end
          end
          default: begin
            if (reg_a_q[0]) begin
              state_d = S_DONE;
            end else begin
              acc_d   = acc_q + CNT_W'(1);
              reg_a_d = reg_a_q >> 1;
              if (last_bit) state_d = S_DONE;
            end
          end
        endcase
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    pronto_d  = (state_d == S_DONE);
    ocupado_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      reg_a_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      mode_q    <= 2'b00;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_a_q   <= reg_a_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.resultado = acc_q;
  assign bus.pronto    = pronto_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.est       = state_q;
endmodule

// File: tb/tb_contador_bits_param.sv
// Bench for contador_bits_param: directed vector table, corner sequences
// and randomized operands against an arithmetic reference model.
module tb_contador_bits_param;
  localparam int W = 16;
  localparam int C = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  contador_bits_param_if #(.WIDTH(W), .CNT_W(C)) bus ();
  contador_bits_param #(.WIDTH(W), .CNT_W(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    int           exp_res;
    int           exp_busy;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] m, input logic [W-1:0] a,
                                    output int res, output int busy);
    int ones = 0;
    int msb  = -1;
    int lz   = 0;
    int tz   = 0;
    for (int i = 0; i < W; i++) begin
      ones += int'(a[i]);
      if (a[i]) msb = i;
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i]) break;
      lz++;
    end
    for (int i = 0; i < W; i++) begin
      if (a[i]) break;
      tz++;
    end
    case (m)
      2'b00: begin res = ones;     busy = (msb < 0) ? 1 : msb + 1; end
      2'b01: begin res = W - ones; busy = W; end
      2'b10: begin res = lz;       busy = (a != 0) ? lz + 1 : W; end
      default: begin res = tz;     busy = (a != 0) ? tz + 1 : W; end
    endcase
  endfunction

  // Issues one request and waits for pronto; busy=-1 flags a timeout.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input bit drop_start,
                        output int busy, output int res);
    int t = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = a;
    @(negedge clk);
    if (drop_start) bus.start = 1'b0;
    busy = 0;
    while (!bus.pronto && t < 200) begin
      if (bus.ocupado) busy++;
      t++;
      @(negedge clk);
    end
    if (!bus.pronto) busy = -1;
    res = int'(bus.resultado);
  endtask

  task automatic finish_op(input string name, input int exp_res);
    bus.start = 1'b0;
    @(negedge clk);
    check({name, " est idle"}, int'(bus.est), 0);
    check({name, " pronto low"}, int'(bus.pronto), 0);
    check({name, " result held"}, int'(bus.resultado), exp_res);
  endtask

  vec_t vecs[$];

  initial begin
    int busy, res, er, eb, t;
    logic [1:0]   m;
    logic [W-1:0] a;

    vecs.push_back('{2'b00, 16'h0000, 0, 1});
    vecs.push_back('{2'b00, 16'h0003, 2, 2});
    vecs.push_back('{2'b01, 16'h00FF, 8, 16});
    vecs.push_back('{2'b11, 16'h0000, 16, 16});
    vecs.push_back('{2'b10, 16'h0010, 11, 12});
    vecs.push_back('{2'b11, 16'h8000, 15, 16});
    vecs.push_back('{2'b10, 16'h0001, 15, 16});
    vecs.push_back('{2'b11, 16'h0001, 0, 1});
    vecs.push_back('{2'b10, 16'h8000, 0, 1});
    vecs.push_back('{2'b10, 16'h0000, 16, 16});
    vecs.push_back('{2'b00, 16'hFFFF, 16, 16});

    reset = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.a     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset est", int'(bus.est), 0);
    check("reset pronto", int'(bus.pronto), 0);
    check("reset ocupado", int'(bus.ocupado), 0);
    check("reset resultado", int'(bus.resultado), 0);
    reset = 1'b0;

    // Held start: DONE persists with a stable result until start drops.
    run_op(2'b00, 16'hB2C5, 1'b0, busy, res);
    check("b2c5 busy", busy, 16);
    check("b2c5 res", res, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2c5 hold est", int'(bus.est), 2);
      check("b2c5 hold res", int'(bus.resultado), 8);
    end
    finish_op("b2c5", 8);

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].a, 1'b1, busy, res);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d res", i), res, vecs[i].exp_res);
      finish_op($sformatf("vec%0d", i), vecs[i].exp_res);
    end

    // Inputs wiggled during BUSY must not affect the latched request.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    bus.a     = 16'hB2C5;
    @(negedge clk);
    busy = 0;
    t = 0;
    while (!bus.pronto && t < 200) begin
      if (bus.ocupado) busy++;
      bus.start = ~bus.start;
      bus.mode  = 2'($urandom);
      bus.a     = W'($urandom);
      t++;
      @(negedge clk);
    end
    check("midbusy busy", busy, 16);
    check("midbusy res", int'(bus.resultado), 8);
    finish_op("midbusy", 8);

    // Reset in the fifth busy cycle of a zeros count.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    bus.a     = 16'h00FF;
    @(negedge clk);
    bus.start = 1'b0;
    busy = 1;
    t = 0;
    while (busy < 5 && t < 50) begin
      @(negedge clk);
      if (bus.ocupado) busy++;
      t++;
    end
    check("rst mid reached", busy, 5);
    reset = 1'b1;
    @(negedge clk);
    check("rst mid est", int'(bus.est), 0);
    check("rst mid pronto", int'(bus.pronto), 0);
    check("rst mid ocupado", int'(bus.ocupado), 0);
    check("rst mid resultado", int'(bus.resultado), 0);
    bus.start = 1'b1;
    @(negedge clk);
    check("rst+start est", int'(bus.est), 0);
    check("rst+start ocupado", int'(bus.ocupado), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = W'($urandom);
        1: a = W'($urandom) >> $urandom_range(0, W - 1);
        2: a = W'($urandom) << $urandom_range(0, W - 1);
        default: a = W'(1) << $urandom_range(0, W - 1);
      endcase
      ref_model(m, a, er, eb);
      run_op(m, a, 1'b1, busy, res);
      check($sformatf("rnd%0d m%0d a%04h busy", i, m, a), busy, eb);
      check($sformatf("rnd%0d m%0d a%04h res", i, m, a), res, er);
      finish_op($sformatf("rnd%0d", i), er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/contador_bits_param.md
Name: contador_bits_param

Overview:
- Parametrised, multi-mode bit counter. It loads a WIDTH-bit operand on a start handshake and examines one bit per clock.
- It returns one of four results: the count of ones, the count of zeros, the leading-zero count or the trailing-zero count.
- It uses the existing level start/pronto handshake and adds a busy flag, a mode select and result hold.
- It sits beside the datapath as a shared utility for normalisation and statistics logic.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2.
- CNT_W, 5, result width; must satisfy CNT_W >= clog2(WIDTH+1) so that the value WIDTH is representable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE and DONE.
- mode  in  2  operation select: 00 ones, 01 zeros, 10 leading zeros (from MSB), 11 trailing zeros (from LSB); sampled only when start is accepted.
- A  in  WIDTH  operand; sampled only when start is accepted.
- resultado  out  CNT_W  count result; valid while pronto=1 and held until the next accepted start.
- pronto  out  1  registered done flag; high in DONE.
- ocupado  out  1  registered busy flag; high in BUSY.
- est  out  2  current state: 00 IDLE, 01 BUSY, 10 DONE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Asserting reset at a clk edge gives state=IDLE, regA=0, acc=0, idx=0, mode_r=00, pronto=0, ocupado=0. This applies from any state, including mid-BUSY; the partial result is discarded. reset has priority over start.
- IDLE:
  - start=0: stay; resultado keeps its last value (0 after reset).
  - start=1 at an edge: regA<=A, mode_r<=mode, acc<=0, idx<=0, go to BUSY.
- BUSY: each cycle examines one bit; idx counts examined bits (0..WIDTH-1). start, mode and A are ignored.
  - mode 00: bit=regA[0]; acc+=bit; regA shifts right with 0 fill.
    - Go to DONE when the shifted value is 0 or idx==WIDTH-1.
    - Busy cycles = max(1, position of highest set bit + 1).
  - mode 01: bit=regA[0]; acc+=~bit; regA shifts right.
    - Always exactly WIDTH busy cycles.
  - mode 10: bit=regA[WIDTH-1].
    - bit=1: go to DONE, acc unchanged.
    - bit=0: acc+=1, regA shifts left, and go to DONE if idx==WIDTH-1.
    - Busy cycles = lz+1 if A!=0, else WIDTH (result WIDTH).
  - mode 11: same as mode 10, but examines regA[0] and shifts right.
    - Busy cycles = tz+1 if A!=0, else WIDTH.
  - acc never exceeds WIDTH, so there is no wrap.
- DONE:
  - pronto=1, resultado=acc, held constant.
  - start=1: stay in DONE.
  - start=0: go to IDLE; pronto falls on that edge.
  - A new request therefore needs start to drop for at least one cycle.
- Output timing: pronto and ocupado are registered decodes of the next state, so pronto rises on the same edge that enters DONE.
- est=11 (unreachable): return to IDLE on the next edge with pronto=0 and ocupado=0.
- Total latency from start accepted to pronto high = busy cycles + 1 edge (the IDLE to BUSY edge).

Test Plan:
- WIDTH=16, CNT_W=5, mode=00, A=16'hB2C5, start pulsed and held → ocupado for 16 cycles, then pronto=1 and resultado=8; start kept high 5 more cycles → remains DONE with resultado=8; start low → IDLE next edge, resultado still 8.
- mode=00, A=16'h0000 → exactly 1 busy cycle, resultado=0. Then A=16'h0003 → 2 busy cycles, resultado=2.
- mode=01, A=16'h00FF → 16 busy cycles, resultado=8. Then mode=11, A=16'h0000 → 16 busy cycles, resultado=16 (no overflow).
- mode=10, A=16'h0010 → 12 busy cycles, resultado=11. Then mode=11, A=16'h8000 → resultado=15. Then A=16'h0001 with mode=10 → resultado=15; same A with mode=11 → 1 busy cycle, resultado=0.
- Change A and mode mid-BUSY, and pulse start while BUSY → result matches the operand and mode latched at accept; no restart.
- Assert reset in cycle 5 of a mode-01 run → next edge est=00, pronto=0, ocupado=0, resultado=0. Assert reset and start together → stays IDLE.
